vga_terminal: RTL and testbench

//  Character-stream front end for the 80x30 VGA text controller. Accepts 7-bit

---
 rtl/vga_terminal.sv | 190 +++++++++++++++++++
 tb/tb_vga_terminal.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_terminal.sv
// Character-stream front end for the 80x30 VGA text controller: decodes ASCII
// bytes, tracks the cursor and issues write / scroll / clear traffic.
module vga_terminal #(
  parameter int unsigned COLS      = 80,
  parameter int unsigned ROWS      = 30,
  parameter int unsigned TAB_WIDTH = 8
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       char_valid_in,
  input  logic [6:0] char_in,
  output logic       char_ready_out,
  input  logic       vga_ready_in,
  output logic       vga_write_out,
  output logic [4:0] vga_row_out,
  output logic [6:0] vga_col_out,
  output logic [6:0] vga_data_out,
  output logic       vga_scroll_out,
  output logic [4:0] cursor_row_out,
  output logic [6:0] cursor_col_out
);

  localparam int unsigned RW = 5;
  localparam int unsigned CW = 7;
  localparam int unsigned DW = 7;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [7:0]    COLS8    = 8'(COLS);
  localparam logic [7:0]    TAB_MASK = 8'(TAB_WIDTH - 1);
  localparam logic [DW-1:0] SPACE    = 7'h20;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    SCROLL,
    SCROLL_WAIT,
    CLEAR
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] cur_row_q, cur_row_d;
  logic [CW-1:0] cur_col_q, cur_col_d;
  logic [RW-1:0] wr_row_q, wr_row_d;
  logic [CW-1:0] wr_col_q, wr_col_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          wr_adv_q, wr_adv_d;      // pending write advances the cursor
  logic          sw_first_q, sw_first_d;  // first SCROLL_WAIT cycle ignores ready
  logic [7:0]    col8, tab8;
  logic          do_adv;

  // State and datapath registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      cur_row_q  <= '0;
      cur_col_q  <= '0;
      wr_row_q   <= '0;
      wr_col_q   <= '0;
      wr_data_q  <= '0;
      wr_adv_q   <= 1'b0;
      sw_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_row_q  <= cur_row_d;
      cur_col_q  <= cur_col_d;
      wr_row_q   <= wr_row_d;
      wr_col_q   <= wr_col_d;
      wr_data_q  <= wr_data_d;
      wr_adv_q   <= wr_adv_d;
      sw_first_q <= sw_first_d;
    end
  end

  // Byte decode, write/clear sequencing and line advance
  always_comb begin
    state_d    = state_q;
    cur_row_d  = cur_row_q;
    cur_col_d  = cur_col_q;
    wr_row_d   = wr_row_q;
    wr_col_d   = wr_col_q;
    wr_data_d  = wr_data_q;
    wr_adv_d   = wr_adv_q;
    sw_first_d = sw_first_q;
    do_adv     = 1'b0;
    col8       = 8'(cur_col_q);
    tab8       = (col8 | TAB_MASK) + 8'd1;

    case (state_q)
      IDLE: begin
        if (char_valid_in) begin
          if (char_in >= 7'h20 && char_in <= 7'h7E) begin
            wr_row_d  = cur_row_q;
            wr_col_d  = cur_col_q;
            wr_data_d = char_in;
            wr_adv_d  = 1'b1;
            state_d   = WRITE;
          end else if (char_in == 7'h0D) begin
            cur_col_d = '0;
          end else if (char_in == 7'h0A) begin
            do_adv = 1'b1;
          end else if (char_in == 7'h08) begin
            if (cur_col_q != '0) begin
              cur_col_d = CW'(col8 - 8'd1);
              wr_row_d  = cur_row_q;
              wr_col_d  = CW'(col8 - 8'd1);
              wr_data_d = SPACE;
              wr_adv_d  = 1'b0;
              state_d   = WRITE;
            end
          end else if (char_in == 7'h09) begin
            if (tab8 >= COLS8) begin
              cur_col_d = '0;
              do_adv    = 1'b1;
            end else begin
              cur_col_d = CW'(tab8);
            end
          end else if (char_in == 7'h0C) begin
            wr_row_d  = '0;
            wr_col_d  = '0;
            wr_data_d = SPACE;
            state_d   = CLEAR;
          end
        end
      end
      WRITE: begin
        if (vga_ready_in) begin
          state_d = IDLE;
          if (wr_adv_q) begin
            if (cur_col_q == LAST_COL) begin
              cur_col_d = '0;
              do_adv    = 1'b1;
            end else begin
              cur_col_d = CW'(col8 + 8'd1);
            end
          end
        end
      end
      SCROLL: begin
        if (vga_ready_in) begin
          state_d    = SCROLL_WAIT;
          sw_first_d = 1'b1;
        end
      end
      SCROLL_WAIT: begin
        if (sw_first_q) begin
          sw_first_d = 1'b0;
        end else if (vga_ready_in) begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (vga_ready_in) begin
          if (wr_col_q == LAST_COL) begin
            wr_col_d = '0;
            if (wr_row_q == LAST_ROW) begin
              cur_row_d = '0;
              cur_col_d = '0;
              state_d   = IDLE;
            end else begin
              wr_row_d = RW'(8'(wr_row_q) + 8'd1);
            end
          end else begin
            wr_col_d = CW'(8'(wr_col_q) + 8'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Bottom row scrolls instead of moving down
    if (do_adv) begin
      if (cur_row_q < LAST_ROW) begin
        cur_row_d = RW'(8'(cur_row_q) + 8'd1);
        state_d   = IDLE;
      end else begin
        state_d = SCROLL;
      end
    end
  end

  assign char_ready_out = (state_q == IDLE) & ~rst_in;
  assign vga_write_out  = ((state_q == WRITE) | (state_q == CLEAR)) & vga_ready_in;
  assign vga_scroll_out = (state_q == SCROLL) & vga_ready_in;
  assign vga_row_out    = wr_row_q;
  assign vga_col_out    = wr_col_q;
  assign vga_data_out   = wr_data_q;
  assign cursor_row_out = cur_row_q;
  assign cursor_col_out = cur_col_q;

endmodule

// File: tb/tb_vga_terminal.sv
// Directed bench for vga_terminal: a byte-level model predicts the VGA event
// stream and cursor; a negedge monitor checks every strobe against it.
module tb_vga_terminal;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int LIMIT = 20000;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       char_valid_in;
  logic [6:0] char_in;
  logic       char_ready_out;
  logic       vga_ready_in;
  logic       vga_write_out;
  logic [4:0] vga_row_out;
  logic [6:0] vga_col_out;
  logic [6:0] vga_data_out;
  logic       vga_scroll_out;
  logic [4:0] cursor_row_out;
  logic [6:0] cursor_col_out;

  vga_terminal dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .char_valid_in  (char_valid_in),
    .char_in        (char_in),
    .char_ready_out (char_ready_out),
    .vga_ready_in   (vga_ready_in),
    .vga_write_out  (vga_write_out),
    .vga_row_out    (vga_row_out),
    .vga_col_out    (vga_col_out),
    .vga_data_out   (vga_data_out),
    .vga_scroll_out (vga_scroll_out),
    .cursor_row_out (cursor_row_out),
    .cursor_col_out (cursor_col_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit is_scroll;
    int row;
    int col;
    int data;
  } ev_t;

  ev_t q[$];
  int  mrow, mcol;
  int  checks = 0;
  int  errors = 0;
  int  n_writes = 0;
  int  n_scrolls = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: screen-level consequences of one accepted byte
  task automatic m_push(input bit s, input int r, input int c, input int d);
    ev_t e;
    e.is_scroll = s; e.row = r; e.col = c; e.data = d;
    q.push_back(e);
  endtask

  task automatic m_line_adv();
    if (mrow < ROWS - 1) mrow++;
    else m_push(1'b1, 0, 0, 0);
  endtask

  task automatic m_accept(input int c);
    if (c >= 32 && c <= 126) begin
      m_push(1'b0, mrow, mcol, c);
      mcol++;
      if (mcol == COLS) begin mcol = 0; m_line_adv(); end
    end else if (c == 13) begin
      mcol = 0;
    end else if (c == 10) begin
      m_line_adv();
    end else if (c == 8) begin
      if (mcol > 0) begin mcol--; m_push(1'b0, mrow, mcol, 32); end
    end else if (c == 9) begin
      mcol = (mcol / 8 + 1) * 8;
      if (mcol >= COLS) begin mcol = 0; m_line_adv(); end
    end else if (c == 12) begin
      for (int r = 0; r < ROWS; r++)
        for (int k = 0; k < COLS; k++) m_push(1'b0, r, k, 32);
      mrow = 0; mcol = 0;
    end
  endtask

  task automatic m_reset();
    q.delete();
    mrow = 0; mcol = 0;
  endtask

  // Monitor: every strobe must match the next predicted event
  always @(negedge clk_in) begin
    if (!rst_in && (vga_write_out || vga_scroll_out)) begin
      ev_t e;
      chk("strobe_while_not_ready", int'(vga_ready_in), 1);
      if (q.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        e = q.pop_front();
        chk("event_kind_scroll", int'(vga_scroll_out), int'(e.is_scroll));
        if (!e.is_scroll) begin
          chk("write_row", int'(vga_row_out), e.row);
          chk("write_col", int'(vga_col_out), e.col);
          chk("write_data", int'(vga_data_out), e.data);
        end
      end
      if (vga_write_out) n_writes++;
      if (vga_scroll_out) n_scrolls++;
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input logic [6:0] c);
    int n = 0;
    while (!char_ready_out && n < LIMIT) begin tick(); n++; end
    if (n >= LIMIT) chk("send_ready_timeout", 1, 0);
    char_valid_in = 1'b1;
    char_in       = c;
    m_accept(int'(c));
    tick();
    char_valid_in = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(char_ready_out && q.size() == 0) && n < LIMIT) begin tick(); n++; end
    chk("done_timeout", int'(n < LIMIT), 1);
    chk("cursor_row_vs_model", int'(cursor_row_out), mrow);
    chk("cursor_col_vs_model", int'(cursor_col_out), mcol);
  endtask

  task automatic send_wait(input logic [6:0] c);
    send(c);
    wait_done();
  endtask

  initial begin
    int w0, s0, cyc, hi;
    rst_in = 1'b1; char_valid_in = 1'b0; char_in = '0; vga_ready_in = 1'b1;
    m_reset();
    #1;
    chk("reset_ready", int'(char_ready_out), 0);
    chk("reset_row", int'(vga_row_out), 0);
    chk("reset_col", int'(vga_col_out), 0);
    chk("reset_data", int'(vga_data_out), 0);
    chk("reset_write", int'(vga_write_out), 0);
    repeat (2) tick();
    rst_in = 1'b0;
    #1;
    chk("post_reset_ready", int'(char_ready_out), 1);
    chk("post_reset_cur_row", int'(cursor_row_out), 0);
    chk("post_reset_cur_col", int'(cursor_col_out), 0);

    // 1: single printable
    send_wait(7'h41);
    chk("t1_writes", n_writes, 1);
    chk("t1_cur_col", int'(cursor_col_out), 1);
    chk("t1_ready_back", int'(char_ready_out), 1);

    // 2: reach 0,79 via tabs and letters, then wrap
    send_wait(7'h0D);
    for (int i = 0; i < 9; i++) send_wait(7'h09);
    chk("t2_tab_col", int'(cursor_col_out), 72);
    for (int i = 0; i < 7; i++) send_wait(7'(8'h61 + i));
    chk("t2_col79", int'(cursor_col_out), 79);
    s0 = n_scrolls;
    send_wait(7'h5A);
    chk("t2_wrap_row", int'(cursor_row_out), 1);
    chk("t2_wrap_col", int'(cursor_col_out), 0);
    chk("t2_no_scroll", n_scrolls, s0);

    // 3: LF on the bottom row scrolls; ready held low afterwards
    for (int i = 0; i < 28; i++) send_wait(7'h0A);
    for (int i = 0; i < 5; i++) send_wait(7'h2E);
    chk("t3_row29", int'(cursor_row_out), 29);
    send(7'h0A);
    tick();
    vga_ready_in = 1'b0;
    hi = 0;
    for (int i = 0; i < 100; i++) begin tick(); if (char_ready_out) hi++; end
    chk("t3_ready_low_while_busy", hi, 0);
    vga_ready_in = 1'b1;
    wait_done();
    chk("t3_scrolls", n_scrolls, s0 + 1);
    chk("t3_cur_row", int'(cursor_row_out), 29);
    chk("t3_cur_col", int'(cursor_col_out), 5);

    // 5: clear screen with ready toggling every 7 cycles
    w0 = n_writes;
    send(7'h0C);
    cyc = 0;
    while (!(char_ready_out && q.size() == 0) && cyc < LIMIT) begin
      tick(); cyc++;
      if (cyc % 7 == 0) vga_ready_in = ~vga_ready_in;
    end
    vga_ready_in = 1'b1;
    chk("t5_clear_timeout", int'(cyc < LIMIT), 1);
    chk("t5_clear_writes", n_writes - w0, 2400);
    chk("t5_home_row", int'(cursor_row_out), 0);
    chk("t5_home_col", int'(cursor_col_out), 0);

    // 4: BS / TAB / CR from 3,10
    for (int i = 0; i < 3; i++) send_wait(7'h0A);
    for (int i = 0; i < 10; i++) send_wait(7'(8'h30 + i));
    w0 = n_writes;
    send_wait(7'h08);
    chk("t4_bs_write", n_writes - w0, 1);
    chk("t4_bs_col", int'(cursor_col_out), 9);
    send_wait(7'h09);
    chk("t4_tab_col", int'(cursor_col_out), 16);
    send_wait(7'h0D);
    chk("t4_cr_col", int'(cursor_col_out), 0);
    w0 = n_writes;
    send_wait(7'h08);
    chk("t4_bs0_nowrite", n_writes, w0);
    chk("t4_bs0_row", int'(cursor_row_out), 3);
    send_wait(7'h07);
    chk("t4_other_col", int'(cursor_col_out), 0);

    // 6a: reset mid-CLEAR
    send(7'h0C);
    repeat (20) tick();
    chk("t6_clear_active", int'(vga_write_out), 1);
    rst_in = 1'b1; m_reset();
    #1;
    chk("t6_clear_write_drop", int'(vga_write_out), 0);
    chk("t6_clear_row0", int'(vga_row_out), 0);
    chk("t6_clear_col0", int'(vga_col_out), 0);
    chk("t6_clear_data0", int'(vga_data_out), 0);
    chk("t6_clear_ready0", int'(char_ready_out), 0);
    tick();
    rst_in = 1'b0;
    #1;
    chk("t6_clear_idle", int'(char_ready_out), 1);
    tick();
    chk("t6_clear_nowrite", int'(vga_write_out), 0);

    // 6b: reset mid-SCROLL
    for (int i = 0; i < 29; i++) send_wait(7'h0A);
    send_wait(7'h78);
    send(7'h0A);
    chk("t6_scroll_active", int'(vga_scroll_out), 1);
    rst_in = 1'b1; m_reset();
    #1;
    chk("t6_scroll_drop", int'(vga_scroll_out), 0);
    chk("t6_scroll_ready0", int'(char_ready_out), 0);
    tick();
    rst_in = 1'b0;
    #1;
    chk("t6_scroll_idle", int'(char_ready_out), 1);
    chk("t6_scroll_cur_row", int'(cursor_row_out), 0);
    chk("t6_scroll_cur_col", int'(cursor_col_out), 0);
    repeat (3) tick();
    chk("t6_no_late_events", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
